uart_tx_fifo: RTL
=================

# uart_tx_fifo

Memory-mapped UART transmitter that sits directly downstream of the IO address decoder. It consumes the decoder's UART-tx write strobe (`io_enable[5]`) and byte (`data_uart[7:0]`) and buffers the bytes in a small FIFO. It serializes them onto the `tx` pin as 8N1 frames, LSB first, and returns status flags the CPU reads back.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 115_200: line rate. `DIV = CLK_FREQ / BAUD` uses integer division and must be ≥ 2. The divider counter is `$clog2(DIV)` bits wide.
- `DEPTH`, default 8: FIFO depth. Must be a power of 2 and ≥ 2.
- `clk`  input  1  system clock. All state updates on the rising edge.
- `rst_n`  input  1  **asynchronous, active-low** reset.
- `wr_en`  input  1  write strobe, connected to decoder `io_enable[5]`. One byte is offered per high cycle.
- `wr_data`  input  8  byte to send, connected to decoder `data_uart`.
- `ovf_clr`  input  1  clears the sticky overflow flag.
- `tx`  output  1  serial line. Idles high.
- `busy`  output  1  high while a frame is on the line (any state except IDLE).
- `full`  output  1  FIFO count == DEPTH.
- `empty`  output  1  FIFO count == 0.
- `count`  output  `$clog2(DEPTH)+1`  number of bytes in the FIFO. Does not include the byte being shifted.
- `overflow`  output  1  sticky flag: a write was dropped because the FIFO was full.

## Operation
- **Reset values:**
  - `tx` = 1, `busy` = 0, `full` = 0, `empty` = 1, `count` = 0, `overflow` = 0.
  - FSM = IDLE; FIFO pointers and divider = 0.
- **FIFO write rule:**
  - A write is accepted iff `wr_en` is high and `full` is low, judged on the pre-edge state.
  - A write while full is dropped and sets `overflow`. This holds even if a pop happens in the same cycle.
- **Simultaneous push and pop:** a write and a pop in the same cycle leave `count` unchanged, and both pointers advance.
- **Pointers:** wrap modulo DEPTH.
- **`overflow` control:**
  - `ovf_clr` clears `overflow`.
  - If a dropped write and `ovf_clr` occur in the same cycle, set wins.
- **FSM states:** IDLE, START, DATA, STOP.
  - **IDLE:** `tx` = 1. If `!empty`, pop the head byte into an 8-bit shift register, clear the divider, and go to START.
  - **START:** `tx` = 0 for DIV cycles, then go to DATA with bit index 0.
  - **DATA:** `tx` = `shift[0]` for DIV cycles per bit, then shift right.
    - After bit index 7 completes, go to STOP.
  - **STOP:** `tx` = 1 for DIV cycles.
    - At the end of STOP, if `!empty`: pop and go directly to START, with no idle gap.
    - Otherwise go to IDLE.
- **Divider:** counts 0..DIV-1. The bit-end event is `div == DIV-1`, and the divider then wraps to 0.
- **`tx` source:** `tx` is driven from a register, never combinationally from the FSM.
- **Reset mid-frame:** an in-flight frame is abandoned. `tx` returns high asynchronously and the FIFO contents are discarded.
- **`wr_data` handling:** `wr_data` is ignored when `wr_en` is low. The decoder holds `io_enable[5]` low on non-UART addresses, so no extra address qualification is needed here.

## Timing
- **Write to start bit:**
  - `wr_en` is high in cycle N with the FIFO empty and the FSM in IDLE. After edge N: `count` = 1 and `empty` = 0.
  - At edge N+1 the byte is popped: state = START, `tx` = 0, `busy` = 1, `count` = 0.
- **Frame length:** exactly 10·DIV cycles from the `tx` fall to the end of the stop bit.
- **Stop-bit end, FIFO empty:** `busy` falls at the same edge where the stop bit ends.
- **Back-to-back bytes:** frames are contiguous. The next start bit begins at the edge where the stop bit ends.
- **Status outputs:** `full`, `empty`, `count` and `overflow` are registered and reflect the state after the last edge.

## Test plan
All tests use the simulation parameters `CLK_FREQ` = 100_000_000 and `BAUD` = 10_000_000, giving DIV = 10, with `DEPTH` = 4.

1. **Reset:** assert `rst_n` low mid-simulation, with no clock edge required.
   - `tx` = 1, `busy` = 0, `empty` = 1, `count` = 0, `overflow` = 0 immediately.
2. **Single byte:** write 0x55 at cycle N.
   - `tx` falls after edge N+1.
   - The line then carries 0,1,0,1,0,1,0,1,0,1, each level held for 10 cycles.
   - `busy` = 0 exactly 100 cycles after the fall.
3. **Back-to-back:** write 0xA3 and then 0x0F on consecutive cycles.
   - Two contiguous frames, 200 cycles total.
   - Data bits LSB first: 1,1,0,0,0,1,0,1, then 1,1,1,1,0,0,0,0.
   - No idle-high gap between the first frame's stop bit and the second frame's start bit.
4. **Overflow:** write 6 bytes 0x01..0x06 on consecutive cycles.
   - The first pop occurs at the second write's edge, so 0x01..0x05 are accepted.
   - The 6th write arrives with `count` = 4 (`full`), is dropped, and `overflow` = 1.
   - Line output is 0x01..0x05 in order.
   - `ovf_clr` then clears `overflow` to 0.
5. **Simultaneous push and pop:** with `count` = 1 and a frame ending, write at the exact pop edge.
   - `count` stays 1.
   - The popped byte starts immediately, and the new byte is sent next.
6. **Reset mid-frame:** pulse `rst_n` low during DATA of 0xFF with 2 bytes queued.
   - `tx` = 1 and `count` = 0.
   - After release with no further writes, the line stays high for 200 cycles.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// CPU-side bus for the FIFO-buffered UART transmitter: write strobe/byte in,
// serial line and status flags out.
interface uart_tx_fifo_if #(
  parameter int DEPTH = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             wr_en;
  logic [7:0]       wr_data;
  logic             ovf_clr;
  logic             tx;
  logic             busy;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             overflow;

  modport master (
    output wr_en, wr_data, ovf_clr,
    input  tx, busy, full, empty, count, overflow
  );

  modport slave (
    input  wr_en, wr_data, ovf_clr,
    output tx, busy, full, empty, count, overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Memory-mapped 8N1 UART transmitter with a small byte FIFO and sticky
// overflow flag; frames go out LSB first, back-to-back with no idle gap.
module uart_tx_fifo #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200,
  parameter int DEPTH    = 8
) (
  input logic           clk,
  input logic           rst_n,
  uart_tx_fifo_if.slave bus
);
  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int DIV_W = $clog2(DIV);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_next;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_idx_next;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_next;
  logic             r_tx;
  logic             w_tx_next;

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_bit_end;

  assign w_full    = (r_count == CNT_FULL);
  assign w_empty   = (r_count == '0);
  assign w_push    = bus.wr_en && !w_full;
  assign w_bit_end = (r_div == DIV_LAST);

  // Storage is not reset; the pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      // A dropped write beats a simultaneous clear.
      if (bus.wr_en && w_full) begin
        r_overflow <= 1'b1;
      end else if (bus.ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_div     <= w_div_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_tx      <= w_tx_next;
    end
  end

  // The line level for the next bit period is computed here so tx stays a flop.
  always_comb begin
    w_state_next   = r_state;
    w_div_next     = r_div;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_tx_next      = r_tx;
    w_pop          = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_tx_next = 1'b1;
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shift_next = r_mem[r_rd_ptr];
          w_div_next   = '0;
          w_state_next = S_START;
          w_tx_next    = 1'b0;
        end
      end

      S_START: begin
        if (w_bit_end) begin
          w_div_next     = '0;
          w_bit_idx_next = '0;
          w_state_next   = S_DATA;
          w_tx_next      = r_shift[0];
        end else begin
          w_div_next = r_div + DIV_W'(1);
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          w_div_next   = '0;
          w_shift_next = {1'b0, r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
            w_state_next = S_STOP;
            w_tx_next    = 1'b1;
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
            w_tx_next      = r_shift[1];
          end
        end else begin
          w_div_next = r_div + DIV_W'(1);
        end
      end

      S_STOP: begin
        if (w_bit_end) begin
          w_div_next = '0;
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_shift_next = r_mem[r_rd_ptr];
            w_state_next = S_START;
            w_tx_next    = 1'b0;
          end else begin
            w_state_next = S_IDLE;
            w_tx_next    = 1'b1;
          end
        end else begin
          w_div_next = r_div + DIV_W'(1);
        end
      end

      default: begin
        w_state_next = S_IDLE;
        w_div_next   = '0;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  assign bus.tx       = r_tx;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
  assign bus.count    = r_count;
  assign bus.overflow = r_overflow;
endmodule
